// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side handshake bundle for the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int Word_Len = 8
);
  localparam int GW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*Word_Len-1:0] req_data;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] req_ready;
  logic [Word_Len-1:0] tx_data_in;
  logic tx_data_valid;
  logic tx_data_ready;
  logic busy;
  logic [GW-1:0] grant_id;
  logic pkt_trunc;
  modport master (
    input req_valid, req_data, req_last, tx_data_ready,
    output req_ready, tx_data_in, tx_data_valid, busy, grant_id, pkt_trunc
  );
  modport slave (
    output req_valid, req_data, req_last, tx_data_ready,
    input req_ready, tx_data_in, tx_data_valid, busy, grant_id, pkt_trunc
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART transmitter with optional tag byte
module uart_tx_arbiter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int Word_Len = 8,
  parameter int N_REQ = 3,
  parameter bit TAG_EN = 1'b1,
  parameter logic [Word_Len-1:0] TAG_BASE = 8'hF0,
  parameter int MAX_PKT = 16
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.master bus
);
  localparam int GW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] last_grant, pick;
  logic [7:0] cnt;
  logic slot_free, any_req, xfer, cur_last, pkt_end, load, hold;
  logic [Word_Len-1:0] cur_data;
  logic unused;
  assign unused = ^CLK_FREQ;
  assign slot_free = !bus.tx_data_valid || bus.tx_data_ready;
  assign any_req = |bus.req_valid;
  assign cur_data = bus.req_data[bus.grant_id*Word_Len +: Word_Len];
  assign cur_last = bus.req_last[bus.grant_id];
  assign bus.req_ready = (state == DATA && slot_free) ? N_REQ'(1) << bus.grant_id : '0;
  assign xfer = state == DATA && slot_free && bus.req_valid[bus.grant_id];
  assign pkt_end = xfer && (cur_last || {1'b0, cnt} + 9'd1 == 9'(MAX_PKT));
  assign load = (state == TAG && slot_free) || xfer;
  assign hold = bus.tx_data_valid && !bus.tx_data_ready;
  // round-robin pick: nearest requesting index after last_grant; last_grant itself ranks lowest
  always_comb begin
    pick = last_grant;
    for (int k = N_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(last_grant) + k) % N_REQ]) pick = GW'((int'(last_grant) + k) % N_REQ);
  end
  // next state: arbitrate in IDLE, emit tag when slot frees, leave DATA at packet end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && any_req) state_nxt = TAG_EN ? TAG : DATA;
    if (state == TAG && slot_free) state_nxt = DATA;
    if (pkt_end) state_nxt = IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nxt;
  // grant bookkeeping, byte counter and the single-entry output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.grant_id <= '0;
      last_grant <= GW'(N_REQ - 1);
      cnt <= '0;
      bus.tx_data_in <= '0;
      bus.tx_data_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.pkt_trunc <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        bus.grant_id <= pick;
        cnt <= '0;
      end
      if (xfer) cnt <= cnt + 8'd1;
      if (pkt_end) last_grant <= bus.grant_id;
      bus.pkt_trunc <= pkt_end && !cur_last;
      if (load) bus.tx_data_in <= xfer ? cur_data : TAG_BASE + Word_Len'(bus.grant_id);
      bus.tx_data_valid <= load || hold;
      bus.busy <= state_nxt != IDLE || load || hold;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, tagging, back-pressure, truncation and reset
module tb_uart_tx_arbiter;
  localparam int W = 8;
  localparam int N = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] rv = '0, rl = '0;
  logic [N*W-1:0] rd = '0;
  logic txr = 1'b1;
  logic sel = 1'b0;
  uart_tx_arbiter_if #(.N_REQ(N), .Word_Len(W)) ia ();
  uart_tx_arbiter_if #(.N_REQ(N), .Word_Len(W)) ib ();
  assign ia.req_valid = rv;
  assign ia.req_data = rd;
  assign ia.req_last = rl;
  assign ia.tx_data_ready = txr;
  assign ib.req_valid = rv;
  assign ib.req_data = rd;
  assign ib.req_last = rl;
  assign ib.tx_data_ready = txr;
  uart_tx_arbiter #(.Word_Len(W), .N_REQ(N), .TAG_EN(1'b1), .TAG_BASE(8'hF0), .MAX_PKT(4)) u_a (
    .clk(clk), .reset(reset), .bus(ia.master));
  uart_tx_arbiter #(.Word_Len(W), .N_REQ(N), .TAG_EN(1'b0), .TAG_BASE(8'hF0), .MAX_PKT(16)) u_b (
    .clk(clk), .reset(reset), .bus(ib.master));
  logic [N-1:0] rr;
  logic [W-1:0] td;
  logic tv, bsy, trunc;
  logic [1:0] gid;
  assign rr = sel ? ib.req_ready : ia.req_ready;
  assign td = sel ? ib.tx_data_in : ia.tx_data_in;
  assign tv = sel ? ib.tx_data_valid : ia.tx_data_valid;
  assign bsy = sel ? ib.busy : ia.busy;
  assign trunc = sel ? ib.pkt_trunc : ia.pkt_trunc;
  assign gid = sel ? ib.grant_id : ia.grant_id;
  logic [W:0] q [N][$];
  logic [W-1:0] rx[$];
  logic [W-1:0] ex[$];
  logic [N-1:0] stall = '0;
  int acc[N];
  int n_chk = 0, n_fail = 0, viol = 0, n_trunc = 0, hold = 0;
  bit bp = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rx(input string tag);
    chk({tag, " len"}, rx.size(), ex.size());
    for (int i = 0; i < ex.size() && i < rx.size(); i++) chk($sformatf("%s[%0d]", tag, i), rx[i], ex[i]);
    rx.delete();
  endtask
  task automatic update_drv();
    logic [W:0] e;
    for (int i = 0; i < N; i++) begin
      e = q[i].size() > 0 ? q[i][0] : '0;
      rv[i] = q[i].size() > 0 && !stall[i];
      rd[i*W +: W] = e[W-1:0];
      rl[i] = e[W];
    end
  endtask
  task automatic push(input int r, input logic [W-1:0] d, input logic l);
    q[r].push_back({l, d});
  endtask
  task automatic tick();
    logic [N-1:0] hs;
    logic ht, pv, pr;
    logic [W-1:0] pd;
    #2;
    hs = rv & rr;
    ht = tv & txr;
    pd = td;
    pv = tv;
    pr = txr;
    if (!txr && tv && rr != 0) viol++;
    if ((rr & ~(N'(1) << gid)) != 0) viol++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) begin
      void'(q[i].pop_front());
      acc[i]++;
    end
    if (ht) rx.push_back(pd);
    if (pv && !pr && (tv !== pv || td !== pd)) viol++;
    if (trunc) n_trunc++;
    if (bp) begin
      if (ht) hold = 1000;
      else if (hold > 0) hold--;
      txr = hold == 0;
    end
    update_drv();
  endtask
  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      acc[i] = 0;
    end
    stall = '0;
    bp = 1'b0;
    hold = 0;
    txr = 1'b1;
    update_drv();
    tick();
    reset = 1'b1;
    rx.delete();
    viol = 0;
    n_trunc = 0;
  endtask
  task automatic drain(input int bound, input string tag);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() > 0 || bsy) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, n < bound, 1);
  endtask
  initial begin
    int n;
    sel = 1'b0;
    do_reset();
    chk("rst tx_valid", tv, 0);
    chk("rst tx_data", td, 0);
    chk("rst busy", bsy, 0);
    chk("rst grant", gid, 0);
    chk("rst ready", rr, 0);
    chk("rst trunc", trunc, 0);
    push(1, 8'h41, 0);
    push(1, 8'h42, 1);
    update_drv();
    tick();
    chk("t1 grant", gid, 1);
    chk("t1 busy", bsy, 1);
    chk("t1 tx_valid", tv, 0);
    chk("t1 ready", rr, 0);
    tick();
    chk("t2 tag", td, 8'hF1);
    chk("t2 tx_valid", tv, 1);
    chk("t2 ready", rr, 3'b010);
    tick();
    tick();
    chk("single last loaded", td, 8'h42);
    chk("single busy after last", bsy, 1);
    tick();
    chk("single busy drop", bsy, 0);
    chk("single tx_valid drop", tv, 0);
    chk("single grant", gid, 1);
    ex = {8'hF1, 8'h41, 8'h42};
    chk_rx("single stream");
    do_reset();
    for (int r = 0; r < N; r++) begin
      push(r, 8'(16 * (r + 1)), 0);
      push(r, 8'(16 * (r + 1) + 1), 1);
      push(r, 8'(16 * (r + 1) + 2), 0);
      push(r, 8'(16 * (r + 1) + 3), 1);
    end
    update_drv();
    drain(200, "rr timeout");
    ex = {8'hF0, 8'h10, 8'h11, 8'hF1, 8'h20, 8'h21, 8'hF2, 8'h30, 8'h31,
          8'hF0, 8'h12, 8'h13, 8'hF1, 8'h22, 8'h23, 8'hF2, 8'h32, 8'h33};
    chk_rx("rr stream");
    chk("rr ready rules", viol, 0);
    do_reset();
    bp = 1'b1;
    push(0, 8'h10, 0);
    push(0, 8'h11, 1);
    push(1, 8'h20, 1);
    update_drv();
    drain(8000, "bp timeout");
    ex = {8'hF0, 8'h10, 8'h11, 8'hF1, 8'h20};
    chk_rx("bp stream");
    chk("bp stable/ready", viol, 0);
    do_reset();
    for (int i = 1; i <= 6; i++) push(2, 8'(8'hA0 + i), i == 6);
    update_drv();
    tick();
    chk("trunc grant", gid, 2);
    push(0, 8'h55, 1);
    push(1, 8'h66, 1);
    update_drv();
    drain(200, "trunc timeout");
    ex = {8'hF2, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hF0, 8'h55, 8'hF1, 8'h66, 8'hF2, 8'hA5, 8'hA6};
    chk_rx("trunc stream");
    chk("trunc pulses", n_trunc, 1);
    do_reset();
    push(1, 8'h71, 0);
    push(1, 8'h72, 0);
    push(1, 8'h73, 1);
    update_drv();
    tick();
    push(2, 8'h81, 1);
    update_drv();
    n = 0;
    while (acc[1] < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("mid byte2 reached", acc[1], 2);
    chk("mid tx holds byte2", td, 8'h72);
    do_reset();
    chk("mid rst tx_valid", tv, 0);
    chk("mid rst busy", bsy, 0);
    chk("mid rst ready", rr, 0);
    push(2, 8'h81, 1);
    push(0, 8'h91, 1);
    update_drv();
    tick();
    chk("mid first grant", gid, 0);
    drain(200, "mid timeout");
    ex = {8'hF0, 8'h91, 8'hF2, 8'h81};
    chk_rx("mid stream");
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 8'(8'h10 + i), i == 3);
    push(1, 8'h20, 1);
    update_drv();
    tick();
    chk("notag grant", gid, 0);
    chk("notag ready", rr, 3'b001);
    chk("notag tx_valid", tv, 0);
    n = 0;
    while (acc[0] < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("notag two bytes", acc[0], 2);
    stall[0] = 1'b1;
    update_drv();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gid !== 2'd0 || rr[1] !== 1'b0) viol++;
    end
    chk("stall grant held", gid, 0);
    chk("stall no other grant", viol, 0);
    chk("stall r1 untouched", q[1].size(), 1);
    stall[0] = 1'b0;
    update_drv();
    drain(200, "notag timeout");
    ex = {8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    chk_rx("notag stream");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
